// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, request-type encodings, FSM states and per-type frame/response lengths
// for the UART register/ALU command protocol.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WR      = 8'hAA;
  localparam logic [7:0] OP_RD      = 8'hBB;
  localparam logic [7:0] OP_ALU_OP  = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CmdWr     = 2'b00,
    CmdRd     = 2'b01,
    CmdAluOp  = 2'b10,
    CmdAluNop = 2'b11
  } cmd_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitRsp,
    StDone
  } state_e;

  // Number of bytes in the request frame, opcode included.
  function automatic logic [2:0] frame_len(cmd_type_e t);
    logic [2:0] n;
    case (t)
      CmdWr:    n = 3'd3;
      CmdRd:    n = 3'd2;
      CmdAluOp: n = 3'd4;
      default:  n = 3'd2;
    endcase
    return n;
  endfunction

  // Number of response bytes expected back.
  function automatic logic [1:0] rsp_len(cmd_type_e t);
    logic [1:0] n;
    case (t)
      CmdWr:   n = 2'd0;
      CmdRd:   n = 2'd1;
      default: n = 2'd2;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_cmd_master_rsp_timer.sv
// Response timeout counter: counts enabled cycles, restarts on clear, and flags the cycle
// on which the count reaches limit-1. A zero limit never expires.
module rsp_timer #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expire
);

  logic [TIMEOUT_W-1:0] cnt_q;

  // Count idle cycles; clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + TIMEOUT_W'(1);
    end
  end

  // Limit is compared live so a change mid-wait applies at once.
  assign expire = en && (limit != '0) && (cnt_q == limit - TIMEOUT_W'(1));

endmodule

// File: rtl/uart_cmd_master.sv
// Host-side command initiator: frames one register/ALU request onto a UART TX byte
// stream, then collects the response bytes from UART RX with an optional timeout.
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned Addr_SIZE  = 4,
  parameter int unsigned TIMEOUT_W  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CMD_VLD,
  output logic                    CMD_RDY,
  input  logic [1:0]              CMD_TYPE,
  input  logic [Addr_SIZE-1:0]    CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [DATA_WIDTH-1:0]   CMD_OPA,
  input  logic [DATA_WIDTH-1:0]   CMD_OPB,
  input  logic [3:0]              CMD_FUN,
  input  logic [TIMEOUT_W-1:0]    TIMEOUT,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VLD,
  input  logic                    TX_RDY,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_VLD,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_VLD,
  output logic                    RSP_TIMEOUT
);

  state_e                  state_q;
  cmd_type_e               typ_q;
  logic [Addr_SIZE-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   opa_q;
  logic [DATA_WIDTH-1:0]   opb_q;
  logic [3:0]              fun_q;
  logic [1:0]              idx_q;
  logic [1:0]              rx_cnt_q;
  logic                    cmd_rdy_q;
  logic                    tx_vld_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic [2*DATA_WIDTH-1:0] rsp_data_q;
  logic                    rsp_vld_q;
  logic                    rsp_timeout_q;

  logic [1:0]            nxt_idx;
  logic [DATA_WIDTH-1:0] nxt_byte;
  logic [DATA_WIDTH-1:0] first_byte;
  logic [DATA_WIDTH-1:0] addr_byte;
  logic [DATA_WIDTH-1:0] fun_byte;
  logic                  last_byte;
  logic                  wait_rsp;
  logic                  rsp_full;
  logic                  timer_clr;
  logic                  timer_en;
  logic                  expire;

  assign nxt_idx   = idx_q + 2'd1;
  assign addr_byte = DATA_WIDTH'(addr_q);
  assign fun_byte  = DATA_WIDTH'(fun_q);
  assign last_byte = ({1'b0, idx_q} == frame_len(typ_q) - 3'd1);
  assign wait_rsp  = (state_q == StWaitRsp);
  assign rsp_full  = (rx_cnt_q == rsp_len(typ_q));
  assign timer_clr = !wait_rsp || RX_VLD;
  assign timer_en  = wait_rsp && !RX_VLD && !rsp_full;

  // Opcode byte for the request being accepted, straight from the live CMD_TYPE.
  always_comb begin
    first_byte = '0;
    unique case (cmd_type_e'(CMD_TYPE))
      CmdWr:     first_byte = OP_WR;
      CmdRd:     first_byte = OP_RD;
      CmdAluOp:  first_byte = OP_ALU_OP;
      CmdAluNop: first_byte = OP_ALU_NOP;
      default:   first_byte = '0;
    endcase
  end

  // Frame byte at index idx_q+1, built from the latched request fields.
  always_comb begin
    nxt_byte = '0;
    unique case (typ_q)
      CmdWr:     nxt_byte = (nxt_idx == 2'd1) ? addr_byte : wdata_q;
      CmdRd:     nxt_byte = addr_byte;
      CmdAluOp: begin
        case (nxt_idx)
          2'd1:    nxt_byte = opa_q;
          2'd2:    nxt_byte = opb_q;
          default: nxt_byte = fun_byte;
        endcase
      end
      CmdAluNop: nxt_byte = fun_byte;
      default:   nxt_byte = '0;
    endcase
  end

  rsp_timer #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_rsp_timer (
    .clk   (CLK),
    .rst   (RST),
    .clr   (timer_clr),
    .en    (timer_en),
    .limit (TIMEOUT),
    .expire(expire)
  );

  // Request FSM with registered handshake, TX and response outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StIdle;
      typ_q         <= CmdWr;
      addr_q        <= '0;
      wdata_q       <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      fun_q         <= '0;
      idx_q         <= '0;
      rx_cnt_q      <= '0;
      cmd_rdy_q     <= 1'b1;
      tx_vld_q      <= 1'b0;
      tx_data_q     <= '0;
      rsp_data_q    <= '0;
      rsp_vld_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_vld_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // cmd_rdy_q is still low on the cycle a timeout pulse is out.
          if (CMD_VLD && cmd_rdy_q) begin
            typ_q      <= cmd_type_e'(CMD_TYPE);
            addr_q     <= CMD_ADDR;
            wdata_q    <= CMD_WDATA;
            opa_q      <= CMD_OPA;
            opb_q      <= CMD_OPB;
            fun_q      <= CMD_FUN;
            idx_q      <= '0;
            rsp_data_q <= '0;
            cmd_rdy_q  <= 1'b0;
            tx_vld_q   <= 1'b1;
            tx_data_q  <= first_byte;
            state_q    <= StSend;
          end else begin
            cmd_rdy_q <= 1'b1;
          end
        end
        StSend: begin
          if (TX_RDY) begin
            if (last_byte) begin
              tx_vld_q <= 1'b0;
              rx_cnt_q <= '0;
              if (typ_q == CmdWr) begin
                rsp_vld_q <= 1'b1;
                state_q   <= StDone;
              end else begin
                state_q <= StWaitRsp;
              end
            end else begin
              idx_q     <= nxt_idx;
              tx_data_q <= nxt_byte;
            end
          end
        end
        StWaitRsp: begin
          // A byte arriving on the expiry cycle wins over the timeout.
          if (rsp_full) begin
            rsp_vld_q <= 1'b1;
            state_q   <= StDone;
          end else if (RX_VLD) begin
            if (rx_cnt_q[0]) begin
              rsp_data_q[2*DATA_WIDTH-1:DATA_WIDTH] <= RX_DATA;
            end else begin
              rsp_data_q[DATA_WIDTH-1:0] <= RX_DATA;
            end
            rx_cnt_q <= rx_cnt_q + 2'd1;
          end else if (expire) begin
            rsp_timeout_q <= 1'b1;
            state_q       <= StIdle;
          end
        end
        StDone: begin
          cmd_rdy_q <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign CMD_RDY     = cmd_rdy_q;
  assign TX_VLD      = tx_vld_q;
  assign TX_DATA     = tx_data_q;
  assign RSP_DATA    = rsp_data_q;
  assign RSP_VLD     = rsp_vld_q;
  assign RSP_TIMEOUT = rsp_timeout_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master: a table of complete requests plus hand-written
// sequences for TX stalls, timeout, expiry-cycle byte, idle RX noise and mid-frame reset.
module tb_uart_cmd_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CMD_VLD;
  logic        CMD_RDY;
  logic [1:0]  CMD_TYPE;
  logic [3:0]  CMD_ADDR;
  logic [7:0]  CMD_WDATA;
  logic [7:0]  CMD_OPA;
  logic [7:0]  CMD_OPB;
  logic [3:0]  CMD_FUN;
  logic [15:0] TIMEOUT;
  logic [7:0]  TX_DATA;
  logic        TX_VLD;
  logic        TX_RDY;
  logic [7:0]  RX_DATA;
  logic        RX_VLD;
  logic [15:0] RSP_DATA;
  logic        RSP_VLD;
  logic        RSP_TIMEOUT;

  int checks = 0;
  int errors = 0;

  uart_cmd_master dut (
    .CLK        (CLK),
    .RST        (RST),
    .CMD_VLD    (CMD_VLD),
    .CMD_RDY    (CMD_RDY),
    .CMD_TYPE   (CMD_TYPE),
    .CMD_ADDR   (CMD_ADDR),
    .CMD_WDATA  (CMD_WDATA),
    .CMD_OPA    (CMD_OPA),
    .CMD_OPB    (CMD_OPB),
    .CMD_FUN    (CMD_FUN),
    .TIMEOUT    (TIMEOUT),
    .TX_DATA    (TX_DATA),
    .TX_VLD     (TX_VLD),
    .TX_RDY     (TX_RDY),
    .RX_DATA    (RX_DATA),
    .RX_VLD     (RX_VLD),
    .RSP_DATA   (RSP_DATA),
    .RSP_VLD    (RSP_VLD),
    .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // tx holds the expected frame with byte 0 in the low byte; rx likewise.
  typedef struct {
    logic [1:0]  typ;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  opa;
    logic [7:0]  opb;
    logic [3:0]  fun;
    int          nb;
    logic [31:0] tx;
    int          nrx;
    logic [15:0] rx;
    logic [15:0] rsp;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [1:0] typ, input logic [3:0] addr,
                              input logic [7:0] wdata, input logic [7:0] opa,
                              input logic [7:0] opb, input logic [3:0] fun, input int nb,
                              input logic [31:0] tx, input int nrx, input logic [15:0] rx,
                              input logic [15:0] rsp);
    vec_t v;
    v.typ = typ; v.addr = addr; v.wdata = wdata; v.opa = opa; v.opb = opb; v.fun = fun;
    v.nb = nb; v.tx = tx; v.nrx = nrx; v.rx = rx; v.rsp = rsp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_rdy"}, 32'(CMD_RDY), 32'd1);
    chk({tag, "_tx_vld"}, 32'(TX_VLD), 32'd0);
    chk({tag, "_tx_data"}, 32'(TX_DATA), 32'd0);
    chk({tag, "_rsp_vld"}, 32'(RSP_VLD), 32'd0);
    chk({tag, "_rsp_to"}, 32'(RSP_TIMEOUT), 32'd0);
    chk({tag, "_rsp_data"}, 32'(RSP_DATA), 32'd0);
  endtask

  // Issue one request with TX_RDY high, check the frame, feed responses, check completion.
  task automatic run_vec(input vec_t v);
    int lat;
    TX_RDY  = 1'b1;
    chk("rdy_before", 32'(CMD_RDY), 32'd1);
    CMD_VLD = 1'b1; CMD_TYPE = v.typ; CMD_ADDR = v.addr; CMD_WDATA = v.wdata;
    CMD_OPA = v.opa; CMD_OPB = v.opb; CMD_FUN = v.fun;
    @(negedge CLK);
    // Fields are latched on accept, so scrambling them now must not matter.
    CMD_VLD = 1'b0; CMD_ADDR = 4'hE; CMD_WDATA = 8'h77; CMD_OPA = 8'h66; CMD_OPB = 8'h55;
    CMD_FUN = 4'h9;
    for (int k = 0; k < v.nb; k++) begin
      chk("tx_vld", 32'(TX_VLD), 32'd1);
      chk("tx_data", 32'(TX_DATA), 32'(v.tx[8*k +: 8]));
      chk("rdy_busy", 32'(CMD_RDY), 32'd0);
      @(negedge CLK);
    end
    chk("tx_done", 32'(TX_VLD), 32'd0);
    for (int r = 0; r < v.nrx; r++) begin
      RX_VLD = 1'b1; RX_DATA = v.rx[8*r +: 8];
      @(negedge CLK);
    end
    RX_VLD = 1'b0;
    lat = 0;
    while (!RSP_VLD && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    chk("rsp_latency", 32'(lat), (v.nrx == 0) ? 32'd0 : 32'd1);
    chk("rsp_data", 32'(RSP_DATA), 32'(v.rsp));
    chk("rsp_no_to", 32'(RSP_TIMEOUT), 32'd0);
    chk("rdy_in_pulse", 32'(CMD_RDY), 32'd0);
    @(negedge CLK);
    chk("rsp_vld_drop", 32'(RSP_VLD), 32'd0);
    chk("rdy_after", 32'(CMD_RDY), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic saw_vld;
    logic [31:0] stall_tx;

    vecs[0] = mk(2'b00, 4'h3, 8'h5A, 8'h00, 8'h00, 4'h0, 3, 32'h005A03AA, 0, 16'h0000, 16'h0000);
    vecs[1] = mk(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 2, 32'h000002BB, 1, 16'h0081, 16'h0081);
    vecs[2] = mk(2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h5, 4, 32'h053412CC, 2, 16'h0146, 16'h0146);
    vecs[3] = mk(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, 2, 32'h000002DD, 2, 16'hBC9A, 16'hBC9A);
    vecs[4] = mk(2'b01, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0, 2, 32'h00000FBB, 1, 16'h007E, 16'h007E);
    vecs[5] = mk(2'b00, 4'h0, 8'hFF, 8'h00, 8'h00, 4'h0, 3, 32'h00FF00AA, 0, 16'h0000, 16'h0000);

    RST = 1'b1; CMD_VLD = 1'b0; CMD_TYPE = 2'b00; CMD_ADDR = '0; CMD_WDATA = '0;
    CMD_OPA = '0; CMD_OPB = '0; CMD_FUN = '0; TIMEOUT = '0; TX_RDY = 1'b1;
    RX_DATA = '0; RX_VLD = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk_reset_outputs("reset");
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // ALU with operands while TX_RDY alternates; each byte must hold through its stall.
    TIMEOUT = '0; TX_RDY = 1'b0;
    CMD_VLD = 1'b1; CMD_TYPE = 2'b10; CMD_OPA = 8'h10; CMD_OPB = 8'h20; CMD_FUN = 4'h0;
    stall_tx = 32'h002010CC;
    @(negedge CLK);
    CMD_VLD = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("stall_vld", 32'(TX_VLD), 32'd1);
      chk("stall_data", 32'(TX_DATA), 32'(stall_tx[8*k +: 8]));
      TX_RDY = 1'b0;
      CMD_VLD = (k == 1); CMD_TYPE = 2'b00;
      @(negedge CLK);
      chk("stall_hold_vld", 32'(TX_VLD), 32'd1);
      chk("stall_hold_data", 32'(TX_DATA), 32'(stall_tx[8*k +: 8]));
      TX_RDY = 1'b1; CMD_VLD = 1'b0;
      @(negedge CLK);
    end
    chk("stall_tx_done", 32'(TX_VLD), 32'd0);
    RX_VLD = 1'b1; RX_DATA = 8'h30;
    @(negedge CLK);
    RX_DATA = 8'h00;
    @(negedge CLK);
    RX_VLD = 1'b0;
    @(negedge CLK);
    chk("stall_rsp_vld", 32'(RSP_VLD), 32'd1);
    chk("stall_rsp_data", 32'(RSP_DATA), 32'h0030);
    @(negedge CLK);

    // RX noise while idle is ignored and the last response is held.
    for (int k = 0; k < 3; k++) begin
      RX_VLD = 1'b1; RX_DATA = 8'hEE;
      @(negedge CLK);
      chk("idle_rx_vld", 32'(RSP_VLD), 32'd0);
      chk("idle_rx_hold", 32'(RSP_DATA), 32'h0030);
      chk("idle_rx_rdy", 32'(CMD_RDY), 32'd1);
    end
    RX_VLD = 1'b0;

    // Read with TIMEOUT=5; the byte lands on the would-be expiry cycle and counts.
    TIMEOUT = 16'd5; TX_RDY = 1'b1;
    CMD_VLD = 1'b1; CMD_TYPE = 2'b01; CMD_ADDR = 4'h1;
    @(negedge CLK);
    CMD_VLD = 1'b0;
    chk("exp_tx0", 32'(TX_DATA), 32'h00BB);
    @(negedge CLK);
    chk("exp_tx1", 32'(TX_DATA), 32'h0001);
    @(negedge CLK);
    chk("exp_tx_done", 32'(TX_VLD), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("exp_no_early_to", 32'(RSP_TIMEOUT), 32'd0);
    end
    RX_VLD = 1'b1; RX_DATA = 8'h5C;
    @(negedge CLK);
    RX_VLD = 1'b0;
    chk("exp_no_to", 32'(RSP_TIMEOUT), 32'd0);
    chk("exp_not_yet", 32'(RSP_VLD), 32'd0);
    @(negedge CLK);
    chk("exp_rsp_vld", 32'(RSP_VLD), 32'd1);
    chk("exp_rsp_data", 32'(RSP_DATA), 32'h005C);
    chk("exp_rsp_no_to", 32'(RSP_TIMEOUT), 32'd0);
    @(negedge CLK);

    // ALU without operands, TIMEOUT=50, only one of two bytes arrives.
    TIMEOUT = 16'd50;
    CMD_VLD = 1'b1; CMD_TYPE = 2'b11; CMD_FUN = 4'h2;
    @(negedge CLK);
    CMD_VLD = 1'b0;
    chk("to_tx0", 32'(TX_DATA), 32'h00DD);
    @(negedge CLK);
    chk("to_tx1", 32'(TX_DATA), 32'h0002);
    @(negedge CLK);
    RX_VLD = 1'b1; RX_DATA = 8'h11;
    @(negedge CLK);
    RX_VLD = 1'b0;
    cnt = 0; saw_vld = 1'b0;
    while (!RSP_TIMEOUT && cnt < 100) begin
      @(negedge CLK);
      cnt++;
      if (RSP_VLD) saw_vld = 1'b1;
    end
    chk("to_cycles", 32'(cnt), 32'd50);
    chk("to_no_rsp_vld", 32'(saw_vld), 32'd0);
    chk("to_rdy_in_pulse", 32'(CMD_RDY), 32'd0);
    @(negedge CLK);
    chk("to_rdy_after", 32'(CMD_RDY), 32'd1);
    chk("to_pulse_drop", 32'(RSP_TIMEOUT), 32'd0);
    chk("to_rsp_hold", 32'(RSP_DATA), 32'h0011);

    // Reset in the middle of a stalled read frame, then a clean write.
    TIMEOUT = '0; TX_RDY = 1'b0;
    CMD_VLD = 1'b1; CMD_TYPE = 2'b01; CMD_ADDR = 4'h7;
    @(negedge CLK);
    CMD_VLD = 1'b0;
    chk("rst_pre_vld", 32'(TX_VLD), 32'd1);
    chk("rst_pre_data", 32'(TX_DATA), 32'h00BB);
    #2 RST = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(negedge CLK);
    RST = 1'b0;
    chk_reset_outputs("postrst");
    run_vec(mk(2'b00, 4'h9, 8'h3C, 8'h00, 8'h00, 4'h0, 3, 32'h003C09AA, 0, 16'h0000,
               16'h0000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
